// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption core. Round keys are expanded forward to round
// key 10 during KEXP, then unwound in reverse during DEC, so no key storage is
// needed beyond the current round key.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request, sampled only while ready=1
//   key         128-bit cipher key, sampled with start
//   ciphertext  128-bit input block, sampled with start
//   ready       high while idle
//   busy        high while a block is in flight (~ready)
//   done        one-cycle pulse when plaintext updates
//   plaintext   result register, held until the next done
module aes_decrypt_iter (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key,
   input  logic [127:0] ciphertext,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [127:0] plaintext
);

   localparam int unsigned BLK_W   = 128;
   localparam int unsigned RND_W   = 4;
   localparam int unsigned LAST_RK = 10;

   typedef enum logic [1:0] {IDLE, KEXP, DEC} fsm_t;

   fsm_t             fsm, fsm_nxt;
   logic [BLK_W-1:0] state_reg, state_nxt;
   logic [BLK_W-1:0] key_reg, key_nxt;
   logic [RND_W-1:0] rnd, rnd_nxt;
   logic [BLK_W-1:0] pt_nxt;
   logic             done_nxt, ready_nxt;
   logic [BLK_W-1:0] fwd_key, inv_key, inv_sr_sb;

   // GF(2^8) arithmetic, polynomial 0x11b
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   // S-boxes built from the field inverse and the AES affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] y;
      y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      return gf_inv(y);
   endfunction

   function automatic logic [7:0] rcon(input logic [RND_W-1:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] g_word(input logic [31:0] w, input logic [7:0] rc);
      logic [31:0] rw;
      rw = {w[23:0], w[31:24]};
      return {sbox(rw[31:24]) ^ rc, sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])};
   endfunction

   function automatic logic [BLK_W-1:0] key_fwd(input logic [BLK_W-1:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ g_word(k[31:0], rc);
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0]  ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Undo one expansion step: w3 must be recovered first, g() needs it
   function automatic logic [BLK_W-1:0] key_inv(input logic [BLK_W-1:0] k, input logic [7:0] rc);
      logic [31:0] p0, p1, p2, p3;
      p3 = k[31:0]  ^ k[63:32];
      p2 = k[63:32] ^ k[95:64];
      p1 = k[95:64] ^ k[127:96];
      p0 = k[127:96] ^ g_word(p3, rc);
      return {p0, p1, p2, p3};
   endfunction

   // Row r rotates right by r: out(r,c) = in(r, c-r)
   function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
      logic [BLK_W-1:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c-r+4)%4))) +: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [BLK_W-1:0] inv_sub_bytes(input logic [BLK_W-1:0] s);
      logic [BLK_W-1:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
      return o;
   endfunction

   function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
      logic [BLK_W-1:0] o;
      logic [7:0]       a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[8*(15-4*c)   +: 8];
         a1 = s[8*(14-4*c)   +: 8];
         a2 = s[8*(13-4*c)   +: 8];
         a3 = s[8*(12-4*c)   +: 8];
         o[8*(15-4*c) +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[8*(14-4*c) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[8*(13-4*c) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[8*(12-4*c) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

   // Round datapath shared by every state
   always_comb begin
      fwd_key   = key_fwd(key_reg, rcon(rnd));
      inv_key   = key_inv(key_reg, rcon(rnd + 4'd1));
      inv_sr_sb = inv_sub_bytes(inv_shift_rows(state_reg));
   end

   // Next-state and next-output logic
   always_comb begin
      fsm_nxt   = fsm;
      state_nxt = state_reg;
      key_nxt   = key_reg;
      rnd_nxt   = rnd;
      pt_nxt    = plaintext;
      done_nxt  = 1'b0;
      case (fsm)
         IDLE: begin
            if (start) begin
               state_nxt = ciphertext;
               key_nxt   = key;
               rnd_nxt   = 4'd1;
               fsm_nxt   = KEXP;
            end
         end
         KEXP: begin
            key_nxt = fwd_key;
            rnd_nxt = rnd + 4'd1;
            if (rnd == RND_W'(LAST_RK)) begin
               state_nxt = state_reg ^ fwd_key;
               rnd_nxt   = 4'd9;
               fsm_nxt   = DEC;
            end
         end
         DEC: begin
            if (rnd != 4'd0) begin
               state_nxt = inv_mix_columns(inv_sr_sb ^ inv_key);
               key_nxt   = inv_key;
               rnd_nxt   = rnd - 4'd1;
            end else begin
               pt_nxt   = inv_sr_sb ^ inv_key;
               done_nxt = 1'b1;
               fsm_nxt  = IDLE;
            end
         end
         default: fsm_nxt = IDLE;
      endcase
      ready_nxt = (fsm_nxt == IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= IDLE;
         state_reg <= '0;
         key_reg   <= '0;
         rnd       <= '0;
         plaintext <= '0;
         done      <= 1'b0;
         ready     <= 1'b1;
         busy      <= 1'b0;
      end else begin
         fsm       <= fsm_nxt;
         state_reg <= state_nxt;
         key_reg   <= key_nxt;
         rnd       <= rnd_nxt;
         plaintext <= pt_nxt;
         done      <= done_nxt;
         ready     <= ready_nxt;
         busy      <= ~ready_nxt;
      end
   end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter: known-answer vectors plus multi-cycle
// corner sequences (back-to-back start, ignored start, reset mid-run).
module tb_aes_decrypt_iter;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [127:0] key;
   logic [127:0] ciphertext;
   logic         ready;
   logic         busy;
   logic         done;
   logic [127:0] plaintext;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
      logic [127:0] k10;
      bit           chk_k10;
   } vec_t;

   vec_t vecs[7];

   aes_decrypt_iter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .key        (key),
      .ciphertext (ciphertext),
      .ready      (ready),
      .busy       (busy),
      .done       (done),
      .plaintext  (plaintext)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // One block: start sampled at edge 0, expect done at edge 20
   task automatic run_vec(input vec_t v);
      int n;
      bit seen;
      start      = 1'b1;
      key        = v.key;
      ciphertext = v.ct;
      cycle();
      start      = 1'b0;
      key        = rnd128();
      ciphertext = rnd128();
      check("busy_after_start", 128'({ready, busy}), 128'(2'b01));
      n    = 0;
      seen = 1'b0;
      for (int i = 1; i <= 30 && !seen; i++) begin
         cycle();
         if (v.chk_k10 && i == 10) check("key_reg_k10", dut.key_reg, v.k10);
         if (done) begin
            seen = 1'b1;
            n    = i;
         end
      end
      check("latency", 128'(n), 128'(20));
      check("plaintext", plaintext, v.pt);
      check("ready_at_done", 128'({ready, busy}), 128'(2'b10));
      cycle();
      check("done_width", 128'(done), 128'(0));
      check("pt_held", plaintext, v.pt);
   endtask

   initial begin
      int done_cnt;
      int t1;
      int t2;
      logic [127:0] pt1;
      logic [127:0] pt2;

      vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1};
      vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                  128'h3243f6a8885a308d313198a2e0370734, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
      vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                  128'h6bc1bee22e409f96e93d7e117393172a, 128'h0, 1'b0};
      vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf5d3d58503b9699de785895a96fdbaaf,
                  128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h0, 1'b0};
      vecs[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h43b1cd7f598ece23881b00e3ed030688,
                  128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'h0, 1'b0};
      vecs[5] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h7b0c785e27e8ad3f8223207104725dd4,
                  128'hf69f2445df4f9b17ad2b417be66c3710, 128'h0, 1'b0};
      vecs[6] = '{128'h00000000000000000000000000000000, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                  128'h00000000000000000000000000000000, 128'h0, 1'b0};

      rst_n      = 1'b0;
      start      = 1'b0;
      key        = '0;
      ciphertext = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready_busy", 128'({ready, busy}), 128'(2'b10));
      check("reset_done", 128'(done), 128'(0));
      check("reset_plaintext", plaintext, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      // Known-answer table
      for (int v = 0; v < 7; v++) run_vec(vecs[v]);

      // start held high across two blocks: second accepted at edge 21
      start      = 1'b1;
      key        = vecs[0].key;
      ciphertext = vecs[0].ct;
      cycle();
      key        = vecs[1].key;
      ciphertext = vecs[1].ct;
      done_cnt = 0; t1 = 0; t2 = 0; pt1 = '0; pt2 = '0;
      for (int i = 1; i <= 50; i++) begin
         cycle();
         if (i == 21) start = 1'b0;
         if (i == 30) check("b2b_pt_held", plaintext, vecs[0].pt);
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) begin t1 = i; pt1 = plaintext; end
            if (done_cnt == 2) begin t2 = i; pt2 = plaintext; end
         end
      end
      check("b2b_done_count", 128'(done_cnt), 128'(2));
      check("b2b_first_time", 128'(t1), 128'(20));
      check("b2b_spacing", 128'(t2 - t1), 128'(21));
      check("b2b_first_pt", pt1, vecs[0].pt);
      check("b2b_second_pt", pt2, vecs[1].pt);

      // start pulses at edges 5 and 12 during a run are ignored
      start      = 1'b1;
      key        = vecs[0].key;
      ciphertext = vecs[0].ct;
      cycle();
      start      = 1'b0;
      key        = vecs[1].key;
      ciphertext = vecs[1].ct;
      done_cnt = 0; t1 = 0; pt1 = '0;
      for (int i = 1; i <= 45; i++) begin
         cycle();
         start = (i == 4 || i == 11);
         if (done) begin
            done_cnt++;
            t1  = i;
            pt1 = plaintext;
         end
      end
      check("ign_done_count", 128'(done_cnt), 128'(1));
      check("ign_done_time", 128'(t1), 128'(20));
      check("ign_pt", pt1, vecs[0].pt);
      check("ign_pt_final", plaintext, vecs[0].pt);

      // Reset asserted at edge 15 of a run
      start      = 1'b1;
      key        = vecs[1].key;
      ciphertext = vecs[1].ct;
      cycle();
      start = 1'b0;
      for (int i = 1; i <= 15; i++) cycle();
      rst_n = 1'b0;
      #1;
      check("rst_ready_busy", 128'({ready, busy}), 128'(2'b10));
      check("rst_done", 128'(done), 128'(0));
      check("rst_plaintext", plaintext, 128'h0);
      check("rst_key_reg", dut.key_reg, 128'h0);
      check("rst_state_reg", dut.state_reg, 128'h0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_ready", 128'({ready, busy, done}), 128'(3'b100));
      @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 25; i++) begin
         cycle();
         if (done) done_cnt++;
      end
      check("rst_no_stray_done", 128'(done_cnt), 128'(0));
      run_vec(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
